// File: rtl/nn_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | nn_pkg : shared widths, defaults and sequencer state encoding        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package nn_pkg;

    localparam int CHUNKS_DEF  = 4;
    localparam int NEURONS_DEF = 10;
    localparam int CHUNK_W     = 128;
    localparam int ACT_W       = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } node_seq_state_t;

endpackage
`default_nettype wire

// File: rtl/argmax_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | argmax_tracker : running unsigned maximum, lower index wins on ties  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module argmax_tracker #(
    parameter int DATA_W = 8,
    parameter int IDX_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              valid,
    input  logic [DATA_W-1:0] data,
    input  logic [IDX_W-1:0]  index,
    output logic [IDX_W-1:0]  max_idx
);

    logic              r_have;
    logic [DATA_W-1:0] r_max;
    logic [IDX_W-1:0]  r_idx;
    logic              w_take;

    // Strict compare keeps the earlier (lower) index on ties.
    assign w_take  = valid && (!r_have || (data > r_max));
    assign max_idx = w_take ? index : r_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_have <= 1'b0;
            r_max  <= '0;
            r_idx  <= '0;
        end else if (clear) begin
            r_have <= 1'b0;
            r_max  <= '0;
            r_idx  <= '0;
        end else if (w_take) begin
            r_have <= 1'b1;
            r_max  <= data;
            r_idx  <= index;
        end
    end

endmodule
`default_nettype wire

// File: rtl/node_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | node_seq : time-multiplexes one node_func across a layer's neurons.  |
// | Optional argmax via NODE_SEQ_ARGMAX_EN. Rev 1.0                      |
// +----------------------------------------------------------------------+
module node_seq
    import nn_pkg::*;
#(
    parameter int CHUNKS   = CHUNKS_DEF,
    parameter int NEURONS  = NEURONS_DEF,
    parameter int NODE_LAT = 1,
    parameter int PIX_AW   = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic [PIX_AW-1:0]                  img_base,
    output logic                               busy,
    output logic                               done,
    output logic [PIX_AW-1:0]                  pix_addr,
    output logic [$clog2(NEURONS*CHUNKS)-1:0]  w_addr,
    output logic [$clog2(NEURONS)-1:0]         b_addr,
    output logic                               node_rst,
    input  logic [ACT_W-1:0]                   node_out,
    output logic                               res_we,
    output logic [$clog2(NEURONS)-1:0]         res_addr,
    output logic [ACT_W-1:0]                   res_data,
    output logic [3:0]                         class_out,
    output logic                               class_valid
);

    localparam int c_CW  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam int c_NW  = $clog2(NEURONS);
    localparam int c_WAW = $clog2(NEURONS*CHUNKS);
    localparam logic [c_CW-1:0] c_CHK_LAST = c_CW'(CHUNKS - 1);
    localparam logic [c_NW-1:0] c_NRN_LAST = c_NW'(NEURONS - 1);

    node_seq_state_t   r_state;
    logic [PIX_AW-1:0] r_img_base;
    logic [c_CW-1:0]   r_chk;
    logic              r_issue;
    logic [NODE_LAT:0] r_tag_last;
    logic [c_NW-1:0]   r_tag_idx [NODE_LAT+1];

`ifdef NODE_SEQ_ARGMAX_EN
    logic            w_start_acc;
    logic [c_NW-1:0] w_max_idx;

    assign w_start_acc = (r_state == ST_IDLE) && start;

    argmax_tracker #(
        .DATA_W (ACT_W),
        .IDX_W  (c_NW)
    ) u_argmax (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (w_start_acc),
        .valid   (res_we),
        .data    (res_data),
        .index   (res_addr),
        .max_idx (w_max_idx)
    );
`else
    assign class_out   = 4'd0;
    assign class_valid = 1'b0;
`endif

    // b_addr doubles as the neuron counter; w_addr is simply sequential.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_img_base <= '0;
            r_chk      <= '0;
            r_issue    <= 1'b0;
            r_tag_last <= '0;
            for (int i = 0; i <= NODE_LAT; i++) r_tag_idx[i] <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pix_addr   <= '0;
            w_addr     <= '0;
            b_addr     <= '0;
            node_rst   <= 1'b1;
            res_we     <= 1'b0;
            res_addr   <= '0;
            res_data   <= '0;
`ifdef NODE_SEQ_ARGMAX_EN
            class_out   <= 4'd0;
            class_valid <= 1'b0;
`endif
        end else begin
            // Tag travels alongside the data: stage 0 matches data at the node.
            r_tag_last[0] <= r_issue && (r_chk == c_CHK_LAST);
            r_tag_idx[0]  <= b_addr;
            for (int i = 1; i <= NODE_LAT; i++) begin
                r_tag_last[i] <= r_tag_last[i-1];
                r_tag_idx[i]  <= r_tag_idx[i-1];
            end
            res_we <= r_tag_last[NODE_LAT];
            if (r_tag_last[NODE_LAT]) begin
                res_data <= node_out;
                res_addr <= r_tag_idx[NODE_LAT];
            end
            node_rst <= !r_issue;
            done     <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state    <= ST_FEED;
                        r_img_base <= img_base;
                        pix_addr   <= img_base;
                        w_addr     <= '0;
                        b_addr     <= '0;
                        r_chk      <= '0;
                        r_issue    <= 1'b1;
                        busy       <= 1'b1;
`ifdef NODE_SEQ_ARGMAX_EN
                        class_out   <= 4'd0;
                        class_valid <= 1'b0;
`endif
                    end
                end
                ST_FEED: begin
                    if ((r_chk == c_CHK_LAST) && (b_addr == c_NRN_LAST)) begin
                        r_state <= ST_DRAIN;
                        r_issue <= 1'b0;
                    end else if (r_chk == c_CHK_LAST) begin
                        r_chk    <= '0;
                        b_addr   <= b_addr + c_NW'(1);
                        pix_addr <= r_img_base;
                        w_addr   <= w_addr + c_WAW'(1);
                    end else begin
                        r_chk    <= r_chk + c_CW'(1);
                        pix_addr <= r_img_base + PIX_AW'(r_chk) + PIX_AW'(1);
                        w_addr   <= w_addr + c_WAW'(1);
                    end
                end
                ST_DRAIN: begin
                    if (res_we && (res_addr == c_NRN_LAST)) begin
                        r_state <= ST_DONE;
                        done    <= 1'b1;
                        busy    <= 1'b0;
`ifdef NODE_SEQ_ARGMAX_EN
                        class_out   <= 4'(w_max_idx);
                        class_valid <= 1'b1;
`endif
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
